// File: rtl/stat_input_seq.sv
// stat_input_seq: operator entry sequencer for a small statistics unit.
// A debounced push-button captures the switch value as a count N, then N
// samples, then an op code. Each captured word is offered downstream on a
// valid/ready handshake. A press is dropped with an error pulse while a
// word is still pending or when the count is out of range.
module stat_input_seq #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_N           = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       btn,
    output logic [7:0] out_data,
    output logic [1:0] out_kind,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] led,
    output logic       err,
    output logic       done
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]    SW_MAX   = 8'(MAX_N);

    typedef enum logic [1:0] {
        S_GET_N      = 2'd0,
        S_GET_SAMPLE = 2'd1,
        S_GET_OP     = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    logic [7:0]    r_sw_s1, r_sw_s2;
    logic          r_btn_s1, r_btn_s2;
    logic [CW-1:0] r_db_cnt;
    logic          r_db_lvl;
    logic          r_press;
    state_t        r_state;
    logic [3:0]    r_n;
    logic [3:0]    r_idx;
    logic [7:0]    r_out_data;
    logic [1:0]    r_out_kind;
    logic          r_out_valid;
    logic [7:0]    r_led;
    logic          r_err;
    logic [3:0]    w_idx_nxt;
    logic          w_n_ok;

    assign w_idx_nxt = r_idx + 4'd1;
    assign w_n_ok    = (r_sw_s2 != 8'd0) && (r_sw_s2 <= SW_MAX);

    assign out_data  = r_out_data;
    assign out_kind  = r_out_kind;
    assign out_valid = r_out_valid;
    assign led       = r_led;
    assign err       = r_err;
    // done is hidden while the op-code word is still waiting for acceptance
    assign done      = (r_state == S_DONE) && !r_out_valid;

    // Two-flop synchronizers for the asynchronous switch and button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Debounce: flip the level after DEBOUNCE_CYCLES disagreeing cycles; a rising flip emits one press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
            r_db_lvl <= 1'b0;
            r_press  <= 1'b0;
        end else if (r_btn_s2 != r_db_lvl) begin
            if (r_db_cnt == CNT_LAST) begin
                r_db_cnt <= '0;
                r_db_lvl <= r_btn_s2;
                r_press  <= r_btn_s2;
            end else begin
                r_db_cnt <= r_db_cnt + CW'(1);
                r_press  <= 1'b0;
            end
        end else begin
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end
    end

    // Entry sequencer with registered capture, handshake and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_GET_N;
            r_n         <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_kind  <= '0;
            r_out_valid <= 1'b0;
            r_led       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_press) begin
                // A pending word (including one handshaking this cycle) blocks any press
                if (r_out_valid) begin
                    r_err <= 1'b1;
                end else begin
                    case (r_state)
                        S_GET_N: begin
                            if (w_n_ok) begin
                                r_n         <= r_sw_s2[3:0];
                                r_idx       <= '0;
                                r_out_data  <= r_sw_s2;
                                r_out_kind  <= 2'd0;
                                r_led       <= r_sw_s2;
                                r_out_valid <= 1'b1;
                                r_state     <= S_GET_SAMPLE;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                        S_GET_SAMPLE: begin
                            r_idx       <= w_idx_nxt;
                            r_out_data  <= r_sw_s2;
                            r_out_kind  <= 2'd1;
                            r_led       <= r_sw_s2;
                            r_out_valid <= 1'b1;
                            if (w_idx_nxt >= r_n) begin
                                r_state <= S_GET_OP;
                            end
                        end
                        S_GET_OP: begin
                            r_out_data  <= r_sw_s2;
                            r_out_kind  <= 2'd2;
                            r_led       <= r_sw_s2;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                        default: begin
                            r_state <= S_GET_N;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_stat_input_seq.sv
// Bench for stat_input_seq: directed scenarios followed by random entry
// sequences, with a queue scoreboard fed by a phase-level reference model.
module tb_stat_input_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       btn;
    logic [7:0] out_data;
    logic [1:0] out_kind;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] led;
    logic       err;
    logic       done;

    stat_input_seq #(.DEBOUNCE_CYCLES(4), .MAX_N(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn      (btn),
        .out_data (out_data),
        .out_kind (out_kind),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .led      (led),
        .err      (err),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // scoreboard entries are {kind, data}
    logic [9:0] sb[$];
    int err_seen = 0;
    int err_exp  = 0;

    // reference model: entry phase 0=count,1=samples,2=op,3=finished
    int         ph      = 0;
    int         n_exp   = 0;
    int         cnt_exp = 0;
    logic [7:0] led_exp = 8'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // monitor: pop and compare on every accepted word, count err cycles
    always @(negedge clk) begin
        if (rst_n && err) err_seen++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {22'd0, out_kind, out_data}, -1);
            end else begin
                logic [9:0] e;
                e = sb.pop_front();
                chk("word_kind", int'(out_kind), int'(e[9:8]));
                chk("word_data", int'(out_data), int'(e[7:0]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void model_reset();
        ph = 0; n_exp = 0; cnt_exp = 0; led_exp = 8'd0;
        sb.delete();
    endfunction

    function automatic void model_press(input int v, input bit pending);
        if (pending) begin
            err_exp++;
            return;
        end
        case (ph)
            0: if (v >= 1 && v <= 10) begin
                   sb.push_back({2'd0, 8'(v)}); led_exp = 8'(v);
                   n_exp = v; cnt_exp = 0; ph = 1;
               end else err_exp++;
            1: begin
                   sb.push_back({2'd1, 8'(v)}); led_exp = 8'(v);
                   cnt_exp++;
                   if (cnt_exp == n_exp) ph = 2;
               end
            2: begin
                   sb.push_back({2'd2, 8'(v)}); led_exp = 8'(v); ph = 3;
               end
            default: ph = 0;
        endcase
    endfunction

    task automatic press(input int v, input bit rdy);
        bit pending;
        pending   = (sb.size() != 0) && !rdy;
        out_ready = rdy;
        sw        = 8'(v);
        model_press(v, pending);
        cyc(3);
        btn = 1'b1;
        cyc(12);
        btn = 1'b0;
        cyc(12);
        chk("led", int'(led), int'(led_exp));
        chk("done", int'(done), int'(ph == 3 && sb.size() == 0));
        chk("err_count", err_seen, err_exp);
    endtask

    initial begin
        int seq[5] = '{3, 7, 9, 2, 1};
        rst_n = 1'b0; sw = 8'd0; btn = 1'b0; out_ready = 1'b1;
        cyc(3);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        cyc(2);

        // full sequence with downstream always ready
        foreach (seq[i]) press(seq[i], 1'b1);
        chk("seq_done", int'(done), 1);
        chk("seq_led", int'(led), 1);
        chk("seq_drain", sb.size(), 0);

        // bounce shorter than debounce window
        btn = 1'b1; cyc(1); btn = 1'b0; cyc(1); btn = 1'b1; cyc(1); btn = 1'b0;
        cyc(20);
        chk("bounce_valid", int'(out_valid), 0);
        chk("bounce_err", err_seen, err_exp);
        chk("bounce_done", int'(done), 1);

        // leave DONE, then out-of-range counts
        press(0, 1'b1);
        press(0, 1'b1);
        press(11, 1'b1);
        chk("range_valid", int'(out_valid), 0);
        chk("range_err", err_seen, 2);

        // back-pressure: second press dropped while word pending
        press(2, 1'b0);
        press(5, 1'b0);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_data", int'(out_data), 2);
        chk("bp_kind", int'(out_kind), 0);
        out_ready = 1'b1;
        cyc(1);
        chk("bp_valid_after", int'(out_valid), 0);
        chk("bp_drain", sb.size(), 0);

        // one sample accepted, then asynchronous reset mid-cycle
        press(7, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data", int'(out_data), 0);
        chk("arst_led", int'(led), 0);
        chk("arst_kind", int'(out_kind), 0);
        chk("arst_valid", int'(out_valid), 0);
        model_reset();
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        press(4, 1'b1);
        chk("arst_seq_drain", sb.size(), 0);

        // button held through reset release yields a single count press
        sw = 8'd5; btn = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        model_reset();
        cyc(3);
        model_press(5, 1'b0);
        rst_n = 1'b1;
        cyc(20);
        btn = 1'b0;
        cyc(12);
        chk("held_led", int'(led), 5);
        chk("held_drain", sb.size(), 0);
        chk("held_err", err_seen, err_exp);

        // random entries with random back-pressure
        for (int k = 0; k < 40; k++) begin
            press(int'($urandom_range(0, 12)), ($urandom_range(0, 3) != 0));
        end
        out_ready = 1'b1;
        for (int t = 0; t < 200 && sb.size() != 0; t++) cyc(1);
        chk("final_drain", sb.size(), 0);
        chk("final_err", err_seen, err_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
